ad_frame_reader: RTL and testbench
==================================

AD_FRAME_READER -- requirements
Module: ad_frame_reader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 32'd50_000_000, max clk cycles spent waiting on an empty FIFO before abort.
REQ-002 SHALL have parameter MAX_BYTES, default 16'd1024, max bytes forwarded per frame before overflow abort.
REQ-003 SHALL have port clk  input  1  50 MHz system clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  frame request, sampled in IDLE only.
REQ-006 SHALL have port scan_go  output  1  one-cycle pulse launching one polling scan.
REQ-007 SHALL have port fifo_empty  input  1  AD FIFO empty flag.
REQ-008 SHALL have port fifo_q  input  8  AD FIFO read data, valid the cycle after fifo_rdreq.
REQ-009 SHALL have port fifo_rdreq  output  1  AD FIFO read strobe.
REQ-010 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-011 SHALL have port tx_valid  output  1  tx_data valid.
REQ-012 SHALL have port tx_ready  input  1  UART transmitter accepts byte.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse, frame forwarded complete.
REQ-015 SHALL have port err  output  2  sticky status: 00 none, 01 timeout, 10 overflow.
REQ-016 SHALL have port byte_cnt  output  16  bytes accepted by UART in current/last frame.

Function
REQ-017 SHALL implement states IDLE, TRIG, WAIT, RD, LATCH, SEND, DONE, ABORT.
REQ-018 IDLE: start=1 -> TRIG; clear err and byte_cnt on this transition; start ignored in all other states.
REQ-019 TRIG: scan_go=1 exactly this cycle; -> WAIT.
REQ-020 WAIT: fifo_empty=0 -> RD, timeout counter cleared; else counter +1; counter reaching TIMEOUT_CYC-1 -> ABORT with err=01.
REQ-021 RD: fifo_rdreq=1 for exactly one cycle; -> LATCH; fifo_rdreq SHALL never assert while fifo_empty=1.
REQ-022 LATCH: register fifo_q into tx_data, set tx_valid=1; -> SEND.
REQ-023 SEND: hold tx_data and tx_valid stable until tx_ready=1; on that cycle byte accepted, tx_valid=0 next cycle, byte_cnt +1.
REQ-024 On acceptance: accepted byte 8'h0A with previous accepted byte 8'h0D -> DONE; else byte_cnt reaching MAX_BYTES -> ABORT with err=10; else -> WAIT.
REQ-025 Terminator check SHALL use bytes of the current frame only; previous-byte register cleared in TRIG.
REQ-026 DONE: done=1 one cycle; -> IDLE. ABORT: -> IDLE, err held until next accepted start.
REQ-027 Minimum latency FIFO non-empty to tx_valid high: 3 cycles (WAIT, RD, LATCH).
REQ-028 tx_ready high while tx_valid low SHALL be ignored; byte_cnt saturates, never wraps.
REQ-029 Timeout counter 32 bits, active only in WAIT, cleared on leaving WAIT.

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE and scan_go, fifo_rdreq, tx_valid, busy, done = 0, tx_data = 8'h00, err = 2'b00, byte_cnt = 0, all counters 0.
REQ-031 Reset mid-SEND SHALL drop tx_valid without waiting for tx_ready; no byte is counted.

Structure
REQ-032 State encoding, terminator bytes 8'h0D/8'h0A and err codes SHALL live in shared package ad_pkg.
REQ-033 Single module, no sub-modules; AD_FIFO and UART transmitter instantiated externally.

Verification
REQ-034 start pulse, FIFO delivers 8'h12,8'h0D,8'h0A, tx_ready always 1 -> three bytes out in order, done pulse, byte_cnt=3, err=00.
REQ-035 FIFO byte 8'h55 with tx_ready low 10 cycles -> tx_data=8'h55 and tx_valid stable all 10 cycles, one acceptance, byte_cnt=1.
REQ-036 TIMEOUT_CYC=100, FIFO stays empty after start -> ABORT at cycle 100 in WAIT, err=01, no fifo_rdreq, busy low afterwards.
REQ-037 MAX_BYTES=4, FIFO streams 8'hAA without terminator -> 4 bytes accepted, err=10, no done pulse.
REQ-038 reset_n low during SEND -> tx_valid=0 same cycle, state IDLE, byte_cnt=0; subsequent start runs full frame normally.
REQ-039 start pulsed while busy -> ignored, single scan_go per frame.

Source files
------------

// File: rtl/ad_pkg.sv
// Shared definitions for the AD frame reader: FSM state encoding,
// frame terminator bytes and sticky error codes.
package ad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT,
        ST_RD,
        ST_LATCH,
        ST_SEND,
        ST_DONE,
        ST_ABORT
    } state_t;

    localparam logic [7:0] BYTE_CR = 8'h0D;
    localparam logic [7:0] BYTE_LF = 8'h0A;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    // Byte counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ad_frame_reader_if.sv
// Data path between the frame reader, the external AD FIFO and the UART
// transmitter. master = frame reader, slave = FIFO/UART side.
interface ad_frame_reader_if;

    logic       fifo_empty;
    logic [7:0] fifo_q;
    logic       fifo_rdreq;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  fifo_empty, fifo_q, tx_ready,
        output fifo_rdreq, tx_data, tx_valid
    );

    modport slave (
        output fifo_empty, fifo_q, tx_ready,
        input  fifo_rdreq, tx_data, tx_valid
    );

endinterface

// File: rtl/ad_frame_reader.sv
// Frame reader: launches one polling scan, drains the AD FIFO byte by byte
// into the UART transmitter and stops on a CR LF terminator, on a FIFO that
// stays empty too long, or when the frame grows past MAX_BYTES.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; err/byte_cnt show the last frame
// TRIG     | scan_go pulse, previous-byte history cleared
// WAIT     | waiting for FIFO data, timeout counter running
// RD       | fifo_rdreq asserted for one cycle
// LATCH    | fifo_q captured into tx_data, tx_valid raised
// SEND     | tx_data/tx_valid held until tx_ready
// DONE     | done pulse after CR LF was accepted
// ABORT    | timeout or overflow, err already set
module ad_frame_reader
    import ad_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000,
    parameter logic [15:0] MAX_BYTES   = 16'd1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                scan_go,
    ad_frame_reader_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err,
    output logic [15:0]         byte_cnt
);

    localparam logic [31:0] TO_LAST = TIMEOUT_CYC - 32'd1;

    state_t      state;
    logic [31:0] wait_cnt;
    logic [7:0]  prev_byte;
    logic [15:0] cnt_next;

    assign cnt_next = sat_inc16(byte_cnt);

    // Frame sequencing FSM; every output is a register set on the transition into its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= 32'd0;
            prev_byte      <= 8'h00;
            scan_go        <= 1'b0;
            bus.fifo_rdreq <= 1'b0;
            bus.tx_data    <= 8'h00;
            bus.tx_valid   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= ERR_NONE;
            byte_cnt       <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_TRIG;
                        scan_go  <= 1'b1;
                        busy     <= 1'b1;
                        err      <= ERR_NONE;
                        byte_cnt <= 16'd0;
                    end
                end
                ST_TRIG: begin
                    scan_go   <= 1'b0;
                    prev_byte <= 8'h00;
                    wait_cnt  <= 32'd0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!bus.fifo_empty) begin
                        wait_cnt       <= 32'd0;
                        bus.fifo_rdreq <= 1'b1;
                        state          <= ST_RD;
                    end else if (wait_cnt == TO_LAST) begin
                        wait_cnt <= 32'd0;
                        err      <= ERR_TIMEOUT;
                        state    <= ST_ABORT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ST_RD: begin
                    bus.fifo_rdreq <= 1'b0;
                    state          <= ST_LATCH;
                end
                ST_LATCH: begin
                    bus.tx_data  <= bus.fifo_q;
                    bus.tx_valid <= 1'b1;
                    state        <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        byte_cnt     <= cnt_next;
                        prev_byte    <= bus.tx_data;
                        // Terminator wins over overflow when both land on the same byte.
                        if (bus.tx_data == BYTE_LF && prev_byte == BYTE_CR) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (cnt_next >= MAX_BYTES) begin
                            err   <= ERR_OVERFLOW;
                            state <= ST_ABORT;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_ABORT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad_frame_reader.sv
// Scoreboard bench for ad_frame_reader: a FIFO model feeds bytes, a frame
// model predicts the forwarded bytes and the frame outcome, and a monitor
// compares every accepted byte and every frame end against the queues.
module tb_ad_frame_reader;
    import ad_pkg::*;

    localparam int MAXB = 4;

    typedef struct {
        int         nbytes;
        bit         dn;
        logic [1:0] e;
    } res_t;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        scan_go, busy, done;
    logic [1:0]  err;
    logic [15:0] byte_cnt;

    ad_frame_reader_if bus();

    ad_frame_reader #(.TIMEOUT_CYC(32'd100), .MAX_BYTES(16'd4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .scan_go(scan_go),
        .bus(bus), .busy(busy), .done(done), .err(err), .byte_cnt(byte_cnt)
    );

    always #10 clk = ~clk;

    logic [7:0] exp_q[$];
    res_t       res_q[$];
    logic [7:0] src[$];
    logic [7:0] fq[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    int ready_mode = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Frame outcome from the rules: stop after CR LF, abort at MAXB bytes,
    // and a frame that runs out of FIFO data times out.
    function automatic res_t model(input byte_q_t bq);
        res_t r;
        int prev;
        prev = -1;
        r.nbytes = 0;
        r.dn = 1'b0;
        r.e = 2'b00;
        foreach (bq[i]) begin
            r.nbytes++;
            if (bq[i] == 8'h0A && prev == 32'h0D) begin
                r.dn = 1'b1;
                return r;
            end
            if (r.nbytes == MAXB) begin
                r.e = 2'b10;
                return r;
            end
            prev = int'(bq[i]);
        end
        r.e = 2'b01;
        return r;
    endfunction

    // UART ready driver
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.tx_ready = 1'($urandom_range(0, 1));
                1:       bus.tx_ready = 1'b1;
                default: bus.tx_ready = 1'b0;
            endcase
        end
    end

    // AD FIFO model: bytes trickle from src into the FIFO with random gaps;
    // a read seen in one cycle pops the head just after the next edge.
    initial begin
        bit rd_pend;
        int gap;
        gap = 0;
        bus.fifo_empty = 1'b1;
        bus.fifo_q = 8'h00;
        forever begin
            @(negedge clk);
            rd_pend = bus.fifo_rdreq;
            if (reset_n && bus.fifo_rdreq)
                chk("rdreq_while_empty", 32'(bus.fifo_empty), 32'd0);
            @(posedge clk);
            #1;
            if (!reset_n) begin
                fq.delete();
                src.delete();
                gap = 0;
            end else begin
                if (rd_pend && fq.size() > 0) bus.fifo_q = fq.pop_front();
                if (gap > 0) gap--;
                else if (src.size() > 0) begin
                    fq.push_back(src.pop_front());
                    gap = int'($urandom_range(0, 12));
                end
            end
            bus.fifo_empty = (fq.size() == 0);
        end
    end

    // Monitor: checks accepted bytes and the outcome of each frame.
    initial begin
        bit pb;
        int scans, rds, dones;
        res_t r;
        logic [7:0] eb;
        pb = 1'b0; scans = 0; rds = 0; dones = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || !reset_n) begin
                pb = 1'b0; scans = 0; rds = 0; dones = 0;
            end else begin
                if (scan_go) scans++;
                if (bus.fifo_rdreq) rds++;
                if (done) dones++;
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL tx_byte_extra: actual=%0h required=none t=%0t", bus.tx_data, $time);
                    end else begin
                        eb = exp_q.pop_front();
                        chk("tx_byte", 32'(bus.tx_data), 32'(eb));
                    end
                end
                if (pb && !busy) begin
                    if (res_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL frame_extra: actual=frame_end required=none t=%0t", $time);
                    end else begin
                        r = res_q.pop_front();
                        chk("done_pulses", 32'(dones), 32'(r.dn));
                        chk("err", 32'(err), 32'(r.e));
                        chk("byte_cnt", 32'(byte_cnt), 32'(r.nbytes));
                        chk("fifo_reads", 32'(rds), 32'(r.nbytes));
                        chk("scan_go_pulses", 32'(scans), 32'd1);
                        chk("bytes_missing", 32'(exp_q.size()), 32'd0);
                    end
                    scans = 0; rds = 0; dones = 0;
                end
                pb = busy;
            end
        end
    end

    task automatic run_frame(input byte_q_t bq, input bit noise, output int bcyc);
        res_t r;
        int k;
        r = model(bq);
        for (int i = 0; i < r.nbytes; i++) begin
            exp_q.push_back(bq[i]);
            src.push_back(bq[i]);
        end
        res_q.push_back(r);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcyc = 0;
        k = 0;
        while (busy && k < 1000) begin
            bcyc++;
            k++;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        if (k >= 1000) chk("frame_hang", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t f;
        int bc, k, sel, len;
        #5 reset_n = 1'b0;
        #20;
        chk("reset_outputs",
            32'({scan_go, bus.fifo_rdreq, bus.tx_valid, busy, done, bus.tx_data, err, byte_cnt}),
            32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en = 1'b1;

        // CR LF frame with ready always high
        ready_mode = 1;
        f = '{8'h12, 8'h0D, 8'h0A};
        run_frame(f, 1'b0, bc);

        // UART stall: data and valid must hold for 10 cycles
        ready_mode = 2;
        f = '{8'h55, 8'h0D, 8'h0A};
        fork
            run_frame(f, 1'b0, bc);
            begin
                k = 0;
                while (!bus.tx_valid && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                for (int i = 0; i < 10; i++) begin
                    chk("stall_hold", 32'({bus.tx_valid, bus.tx_data}), 32'h155);
                    @(negedge clk);
                end
                ready_mode = 1;
            end
        join

        // FIFO never fills: abort after 100 WAIT cycles
        ready_mode = 0;
        f.delete();
        run_frame(f, 1'b0, bc);
        chk("timeout_busy_cycles", 32'(bc), 32'd102);
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        chk("busy_after_abort", 32'(busy), 32'd0);

        // unterminated stream hits the byte limit
        f = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        run_frame(f, 1'b0, bc);

        // reset while a byte sits in SEND
        mon_en = 1'b0;
        ready_mode = 2;
        src.push_back(8'h33);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!bus.tx_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("send_reached", 32'(bus.tx_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("reset_in_send", 32'({bus.tx_valid, busy, bus.tx_data, byte_cnt}), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        res_q.delete();
        mon_en = 1'b1;
        ready_mode = 0;
        f = '{8'h12, 8'h0D, 8'h0A};
        run_frame(f, 1'b1, bc);

        // random frames, start toggled while busy on odd frames
        for (int n = 0; n < 40; n++) begin
            f.delete();
            len = int'($urandom_range(0, 4));
            for (int i = 0; i < len; i++) begin
                sel = int'($urandom_range(0, 3));
                if (sel == 0)      f.push_back(8'h0D);
                else if (sel == 1) f.push_back(8'h0A);
                else               f.push_back(8'($urandom));
            end
            if ($urandom_range(0, 5) != 0) begin
                f.push_back(8'h0D);
                f.push_back(8'h0A);
            end
            run_frame(f, 1'(n % 2), bc);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
